// File: rtl/stack_pkg.sv
// Shared constants for the RPN stack controller: data widths, opcodes and FSM encodings.
package stack_pkg;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 5;

  typedef enum logic [2:0] {
    OP_PUSH = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_DUP  = 3'd6,
    OP_PEEK = 3'd7
  } op_e;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_POP_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_A = 3'd2;
  localparam logic [2:0] ST_POP_A  = 3'd3;
  localparam logic [2:0] ST_PUSH_R = 3'd4;
  localparam logic [2:0] ST_SETTLE = 3'd5;
  localparam logic [2:0] ST_OUT    = 3'd6;
  localparam logic [2:0] ST_ERROR  = 3'd7;

  function automatic logic is_binop(op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR);
  endfunction

endpackage

// File: rtl/stack_rpn_ctrl_if.sv
// Command handshake between a host and the RPN controller.
interface stack_rpn_ctrl_if;
  import stack_pkg::*;

  logic          cmd_stb;
  logic [2:0]    cmd_op;
  logic [DW-1:0] cmd_dat;
  logic          cmd_ack;

  modport master (output cmd_stb, output cmd_op, output cmd_dat, input cmd_ack);
  modport slave  (input cmd_stb, input cmd_op, input cmd_dat, output cmd_ack);

endinterface

// File: rtl/rpn_alu.sv
// Combinational result mux for the binary opcodes; a is the deeper operand.
module rpn_alu
  import stack_pkg::*;
(
  input  op_e           op_i,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] res_o
);

  always_comb begin
    res_o = '0;
    case (op_i)
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/stack_rpn_ctrl.sv
// Sequences PUSH/DUP/PEEK and binary RPN ops against an external registered-top stack.
//
// state  | meaning
// IDLE   | ready, cmd_ack=1, top of stack valid on stk_pop_dat_i
// POP_B  | pop operand B (latched at accept)
// WAIT_A | let the stack register the new top
// POP_A  | latch operand A, pop it, compute result
// PUSH_R | push the pending value (result, PUSH data or DUP copy)
// SETTLE | let the stack register the pushed top
// OUT    | PEEK result pulse
// ERROR  | one-cycle error pulse for underflow/overflow
module stack_rpn_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned DEPTH = stack_pkg::DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  stack_rpn_ctrl_if.slave        cmd,
  output logic                   stk_push_stb_o,
  output logic [DW-1:0]          stk_push_dat_o,
  output logic                   stk_pop_stb_o,
  input  logic [DW-1:0]          stk_pop_dat_i,
  output logic                   res_stb_o,
  output logic [DW-1:0]          res_dat_o,
  output logic                   err_o,
  output logic [CW-1:0]          depth_o
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] depth_q, depth_d;
  op_e           op_q, op_d;
  logic [DW-1:0] b_q, b_d;
  logic [DW-1:0] res_q, res_d;
  logic [DW-1:0] alu_res;
  op_e           cmd_op;

  assign cmd_op = op_e'(cmd.cmd_op);

  rpn_alu u_alu (
    .op_i  (op_q),
    .a_i   (stk_pop_dat_i),
    .b_i   (b_q),
    .res_o (alu_res)
  );

  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    op_d    = op_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_stb) begin
          op_d = cmd_op;
          case (cmd_op)
            OP_PUSH: begin
              if (depth_q == FULL) begin
                state_d = ST_ERROR;
              end else begin
                res_d   = cmd.cmd_dat;
                state_d = ST_PUSH_R;
              end
            end
            OP_DUP: begin
              if ((depth_q == '0) || (depth_q == FULL)) begin
                state_d = ST_ERROR;
              end else begin
                res_d   = stk_pop_dat_i;
                state_d = ST_PUSH_R;
              end
            end
            OP_PEEK: begin
              if (depth_q == '0) begin
                state_d = ST_ERROR;
              end else begin
                res_d   = stk_pop_dat_i;
                state_d = ST_OUT;
              end
            end
            default: begin
              if (depth_q < CW'(2)) begin
                state_d = ST_ERROR;
              end else begin
                b_d     = stk_pop_dat_i;
                state_d = ST_POP_B;
              end
            end
          endcase
        end
      end
      ST_POP_B: begin
        depth_d = depth_q - CW'(1);
        state_d = ST_WAIT_A;
      end
      ST_WAIT_A: state_d = ST_POP_A;
      ST_POP_A: begin
        res_d   = alu_res;
        depth_d = depth_q - CW'(1);
        state_d = ST_PUSH_R;
      end
      ST_PUSH_R: begin
        depth_d = depth_q + CW'(1);
        state_d = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_IDLE;
      ST_OUT:    state_d = ST_IDLE;
      ST_ERROR:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      depth_q <= '0;
      op_q    <= OP_PUSH;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      op_q    <= op_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign cmd.cmd_ack     = (state_q == ST_IDLE);
  assign stk_push_stb_o  = (state_q == ST_PUSH_R);
  assign stk_push_dat_o  = stk_push_stb_o ? res_q : '0;
  assign stk_pop_stb_o   = (state_q == ST_POP_B) || (state_q == ST_POP_A);
  // Only binary ops report their pushed value as a result; PUSH/DUP stay silent.
  assign res_stb_o       = ((state_q == ST_PUSH_R) && is_binop(op_q)) || (state_q == ST_OUT);
  assign res_dat_o       = res_stb_o ? res_q : '0;
  assign err_o           = (state_q == ST_ERROR);
  assign depth_o         = depth_q;

endmodule
